// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front end: turns one byte-addressed request at a time into
// word-indexed data_mem accesses, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

    logic                  accept;
    logic                  req_err;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] store_merge;

    assign accept  = req_valid && (state_q == S_IDLE);
    assign req_err = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_addr[DATA_WIDTH-1:2] >= (DATA_WIDTH-2)'(DEPTH));

    // Little-endian lane extraction and extension of the returned word.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
        rd_byte  = mem_rdata[7:0];
        load_ext = mem_rdata;
        case (addr_q[1:0])
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{(DATA_WIDTH-8){rd_byte[7] & ~uns_q}}, rd_byte};
            SZ_HALF: load_ext = {{(DATA_WIDTH-16){rd_half[15] & ~uns_q}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        store_merge = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    store_merge = {mem_rdata[31:8], wdata_q[7:0]};
                2'd1:    store_merge = {mem_rdata[31:16], wdata_q[7:0], mem_rdata[7:0]};
                2'd2:    store_merge = {mem_rdata[31:24], wdata_q[7:0], mem_rdata[15:0]};
                default: store_merge = {wdata_q[7:0], mem_rdata[23:0]};
            endcase
        end else begin
            store_merge = addr_q[1] ? {wdata_q[15:0], mem_rdata[15:0]}
                                    : {mem_rdata[31:16], wdata_q[15:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    err_d    = req_err;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    mwdata_d = req_wdata;
                    if (req_err)
                        state_d = S_RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = S_RDATA;
            S_RDATA: begin
                if (we_q) begin
                    mwdata_d = store_merge;
                    state_d  = S_WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Outputs are gated by state so reset zeroes them without waiting for a clock.
    assign req_ready  = (state_q == S_IDLE);
    assign mem_read   = (state_q == S_RD);
    assign mem_write  = (state_q == S_WR);
    assign mem_addr   = (state_q == S_IDLE) ? '0 : {2'b00, addr_q[DATA_WIDTH-1:2]};
    assign mem_wdata  = (state_q == S_WR) ? mwdata_q : '0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a synchronous data_mem behind the DUT,
// directed cases followed by random requests checked against a byte-level model.
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // data_mem stand-in: one-cycle synchronous read, loaded with a known pattern.
    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        mem_load = 1'b1;

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
        end else begin
            if (mem_write && mem_addr < DEPTH) env_mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_read)
                mem_rdata <= (mem_addr < DEPTH) ? env_mem[mem_addr[7:0]] : 32'hDEADBEEF;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    int          resp_cyc, rd_cyc, wr_cyc, n_rd, n_wr, viol, extra;
    logic        got_err;
    logic [31:0] got_rdata, got_rd_addr, got_wr_addr, got_wdata;

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        logic [31:0] idx, old, val, mask, exp_rdata, exp_store;
        bit          e;
        int          lat, sh, exp_nrd, exp_nwr;
        idx = addr >> 2;
        e   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (idx >= DEPTH);
        lat = e ? 1 : (!we ? 3 : (size == 2'b10 ? 2 : 4));
        sh  = int'(addr[1:0]) * 8;
        old = e ? 32'h0 : ref_mem[idx[7:0]];
        val = old >> sh;
        if (size == 2'b00) begin
            val = val & 32'hFF;
            if (!uns && val[7]) val = val | 32'hFFFFFF00;
        end else if (size == 2'b01) begin
            val = val & 32'hFFFF;
            if (!uns && val[15]) val = val | 32'hFFFF0000;
        end
        exp_rdata = (e || we) ? 32'h0 : val;
        mask = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
        mask = mask << sh;
        exp_store = (old & ~mask) | ((wdata << sh) & mask);
        exp_nrd = (!e && (!we || size != 2'b10)) ? 1 : 0;
        exp_nwr = (!e && we) ? 1 : 0;

        @(negedge clk);
        check("idle_ready", {31'b0, req_ready}, 32'h1);
        check("idle_addr", mem_addr, 32'h0);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;

        resp_cyc = -1; rd_cyc = -1; wr_cyc = -1; n_rd = 0; n_wr = 0; viol = 0;
        got_err = 1'b0; got_rdata = '0; got_rd_addr = '0; got_wr_addr = '0; got_wdata = '0;
        for (int c = 1; c <= 12 && resp_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_read)  begin n_rd++; rd_cyc = c; got_rd_addr = mem_addr; end
            if (mem_write) begin n_wr++; wr_cyc = c; got_wr_addr = mem_addr; got_wdata = mem_wdata; end
            if (mem_read && mem_write) viol++;
            if (!mem_write && mem_wdata !== 32'h0) viol++;
            if (req_ready) viol++;
            if (resp_valid) begin
                resp_cyc = c; got_err = resp_err; got_rdata = resp_rdata;
            end else if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
                viol++;
            end
        end

        if (hold) begin
            req_valid = 1'b0;
            extra = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (mem_read || mem_write || resp_valid) extra++;
            end
            check("no_double_accept", extra, 0);
        end

        check("resp_cycle", resp_cyc, lat);
        check("resp_err", {31'b0, got_err}, {31'b0, e});
        check("resp_rdata", got_rdata, exp_rdata);
        check("read_count", n_rd, exp_nrd);
        check("write_count", n_wr, exp_nwr);
        check("hold_rules", viol, 0);
        if (exp_nrd == 1) begin
            check("rd_cycle", rd_cyc, 1);
            check("rd_addr", got_rd_addr, idx);
        end
        if (exp_nwr == 1) begin
            check("wr_cycle", wr_cyc, lat - 1);
            check("wr_addr", got_wr_addr, idx);
            check("wr_data", got_wdata, exp_store);
            ref_mem[idx[7:0]] = exp_store;
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_ready"},  {31'b0, req_ready},  32'h1);
        check({tag, "_rvalid"}, {31'b0, resp_valid}, 32'h0);
        check({tag, "_rerr"},   {31'b0, resp_err},   32'h0);
        check({tag, "_rdata"},  resp_rdata,          32'h0);
        check({tag, "_mread"},  {31'b0, mem_read},   32'h0);
        check({tag, "_mwrite"}, {31'b0, mem_write},  32'h0);
        check({tag, "_maddr"},  mem_addr,            32'h0);
        check({tag, "_mwdata"}, mem_wdata,           32'h0);
    endtask

    initial begin
        int          wr_seen;
        logic [1:0]  sz;
        logic [31:0] a;
        int          mode, pick;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset("reset");
        mem_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the block's usage scenarios.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A580F0, 1'b0);
        check("tp_word_store_data", got_wdata, 32'hA5A580F0);
        check("tp_word_store_addr", got_wr_addr, 32'h4);
        run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
        check("tp_lb_signed", got_rdata, 32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
        check("tp_lb_unsigned", got_rdata, 32'h00000080);
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        check("tp_lb_hi_signed", got_rdata, 32'hFFFFFFA5);
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b0);
        check("tp_sh_merge", got_wdata, 32'hBEEF80F0);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        check("tp_lw_after_sh", got_rdata, 32'hBEEF80F0);

        run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        run_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0);
        run_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h55, 1'b0);
        run_req(1'b0, 2'b00, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0);

        run_req(1'b1, 2'b10, 1'b0, 32'(4 * (DEPTH - 1)), 32'hC0FFEE11, 1'b0);
        check("edge_store_addr", got_wr_addr, 32'(DEPTH - 1));
        run_req(1'b0, 2'b10, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0);
        check("edge_load_data", got_rdata, 32'hC0FFEE11);

        // Reset asserted between clock edges while a byte store sits in RDATA.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h0000007E; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_seen = 0;
        #1;
        rst = 1'b1;
        #1;
        check_outputs_reset("midop_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
        end
        check("midop_no_write", wr_seen, 0);
        check("midop_word_kept", env_mem[8], ref_mem[8]);
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);

        // Random traffic over a small address window plus the range boundary.
        for (int n = 0; n < 80; n++) begin
            mode = $urandom_range(0, 7);
            if (mode == 0)      a = 32'(4 * DEPTH) + $urandom_range(0, 15);
            else if (mode == 1) a = 32'(4 * (DEPTH - 1)) + $urandom_range(0, 3);
            else                a = $urandom_range(0, 63);
            pick = $urandom_range(0, 7);
            sz = (pick < 3) ? 2'b00 : (pick < 5) ? 2'b01 : (pick < 7) ? 2'b10 : 2'b11;
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                    ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store requester driving the data_mem port: mem_read, mem_write, addr, write_data, read_data. It is the initiator end of that interface.
- Accepts one byte-addressed load or store at a time from the MEM pipeline stage over a valid/ready handshake.
- Translates each request into word-indexed data_mem accesses, accounting for the 1-cycle synchronous read latency.
- Performs read-modify-write for byte/halfword stores and sign/zero-extends load data. Returns one response per request.

Parameters:
- DATA_WIDTH, 32 (codes_pkg), word and address width; block requires 32 (4 byte lanes).
- DEPTH, codes_pkg DEPTH (256), number of words in data_mem; word index >= DEPTH is out of range.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request (IDLE only)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned/illegal-size/out-of-range, qualified by resp_valid
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- mem_read  out  1  to data_mem mem_read
- mem_write  out  1  to data_mem mem_write
- mem_addr  out  DATA_WIDTH  word index = req_addr>>2, zero-extended
- mem_wdata  out  DATA_WIDTH  to data_mem write_data
- mem_rdata  in  DATA_WIDTH  from data_mem read_data, valid the cycle after mem_read sampled high

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0 except req_ready=1. Latched request is cleared. No mem_write may follow reset.
- Handshake: request is accepted on the edge where req_valid && req_ready. All request fields are latched; inputs are ignored until the next IDLE. No response back-pressure.
- Error check at accept:
  - size=11 → error.
  - halfword with addr[0]≠0 → error.
  - word with addr[1:0]≠0 → error.
  - (addr>>2) >= DEPTH → error.
  - On error: no memory access occurs.
- FSM states: IDLE, RD, RDATA, WR, RESP.
  - IDLE: req_ready=1. On accept: error→RESP; load→RD; word store→WR; byte/half store→RD.
  - RD: mem_read=1, mem_addr=word index → RDATA.
  - RDATA: mem_rdata is valid.
    - Load: select lane (byte lane=addr[1:0], half lane=addr[1], little-endian), extend, register into resp_rdata → RESP.
    - Sub-word store: merge req_wdata low byte/half into the selected lane of mem_rdata, register as mem_wdata → WR.
  - WR: mem_write=1, mem_addr, mem_wdata driven → RESP.
  - RESP: resp_valid=1 for exactly one cycle with resp_err/resp_rdata → IDLE.
- Latency (accept edge = cycle 0; resp_valid high during cycle N):
  - load N=3
  - word store N=2
  - sub-word store N=4
  - error N=1
- Throughput: next request is accepted in the IDLE cycle after RESP.
- Hold rules:
  - mem_read/mem_write are never both 1.
  - mem_addr=0 in IDLE; latched word index otherwise.
  - mem_wdata=0 outside WR.
  - resp_rdata and resp_err are 0 outside RESP.
- Boundary cases:
  - Word index DEPTH-1 is legal.
  - Byte address 4*DEPTH is an error.
  - req_valid held high across busy cycles is not double-accepted.

Test Plan:
- Word store 0xA5A580F0 to 0x10 → mem_write=1 only in cycle 1 with mem_addr=4 and mem_wdata=0xA5A580F0; resp_valid in cycle 2, resp_err=0.
- Byte loads at 0x11 (word 4 = 0xA5A580F0):
  - signed → mem_read cycle 1 (mem_addr=4); resp_valid cycle 3, resp_rdata=0xFFFFFF80.
  - unsigned → 0x00000080.
  - 0x13 signed → 0xFFFFFFA5.
- Halfword store 0x1234BEEF to 0x12 → mem_read cycle 1, mem_write cycle 3 with mem_wdata=0xBEEF80F0; resp cycle 4; subsequent word load 0x10 returns 0xBEEF80F0.
- Errors, each → resp_valid cycle 1 with resp_err=1 and resp_rdata=0, mem_read/mem_write never asserted:
  - word load at 0x06
  - halfword at 0x03
  - size=11
  - byte load at 4*DEPTH
- Legal edge: word store/load at 4*(DEPTH-1) → mem_addr=DEPTH-1, data round-trips.
- Reset mid-op: assert rst asynchronously while in RDATA of a byte store → outputs 0 immediately, req_ready=1, no mem_write ever; target word unchanged. req_valid held through a busy load is accepted exactly once.
